// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: accepts PC fetch requests, returns the stored 32-bit word.
// Latency: resp_valid rises LATENCY cycles after the accept cycle; one transaction in flight.
// Backpressure: req_ready is low from accept until the response handshake completes.
//
// Ports: clk/rst (sync, active-high); req_valid/req_ready/req_addr fetch request channel;
//        resp_valid/resp_ready/resp_instr/resp_err response channel; ld_en/ld_addr/ld_data
//        synchronous preload port; fetch_cnt counts completed response handshakes.
// Optional feature macro: IMEM_OOR_EBREAK_EN -- errored fetches return ebreak instead of zero.
module imem_fetch_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic        resp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] fetch_cnt
);

  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam int CW   = $clog2(LATENCY + 1);

  // One past the last valid byte address, kept 33 bits wide so a map that
  // ends exactly at 2^32 does not wrap to zero.
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

`ifdef IMEM_OOR_EBREAK_EN
  localparam logic [31:0] ERR_INSTR = 32'h00100073;
`else
  localparam logic [31:0] ERR_INSTR = 32'h00000000;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state;
  logic [CW-1:0]   lat_cnt;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            req_ok;
  logic            ld_ok;
  logic [IDXW-1:0] req_idx;
  logic [IDXW-1:0] ld_idx;

  assign req_ok = (req_addr[1:0] == 2'b00) &&
                  ({1'b0, req_addr} >= {1'b0, BASE_ADDR}) &&
                  ({1'b0, req_addr} <  END_ADDR);
  assign ld_ok  = (ld_addr[1:0] == 2'b00) &&
                  ({1'b0, ld_addr} >= {1'b0, BASE_ADDR}) &&
                  ({1'b0, ld_addr} <  END_ADDR);

  // Only meaningful when the matching *_ok is set; otherwise unused.
  assign req_idx = IDXW'((req_addr - BASE_ADDR) >> 2);
  assign ld_idx  = IDXW'((ld_addr  - BASE_ADDR) >> 2);

  assign req_ready = (state == IDLE) && !rst;

  // Preload port. Array contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_instr <= 32'h0;
      resp_err   <= 1'b0;
      fetch_cnt  <= 32'h0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Array is read here with the pre-edge contents, so a load to the
            // same word in the accept cycle is not visible to this response.
            resp_err   <= !req_ok;
            resp_instr <= req_ok ? mem[req_idx] : ERR_INSTR;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              state   <= WAIT;
              lat_cnt <= CW'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - CW'(1);
          // The decrement that reaches zero is also the edge that raises resp_valid.
          if (lat_cnt <= CW'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            fetch_cnt  <= fetch_cnt + 32'd1;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: LATENCY=1 and LATENCY=3 instances share the preload port,
// each with its own request/response channel, checked against a word-array reference model.
module tb_imem_fetch_responder;

  localparam logic [31:0] BASE  = 32'h80000000;
  localparam int          DEPTH = 1024;
`ifdef IMEM_OOR_EBREAK_EN
  localparam logic [31:0] ERR_INSTR = 32'h00100073;
`else
  localparam logic [31:0] ERR_INSTR = 32'h00000000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [31:0] req_addr   [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_instr [2];
  logic        resp_err   [2];
  logic [31:0] fetch_cnt  [2];
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  int nchecks = 0;
  int nerr    = 0;

  // Reference model state
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] mdl_cnt [2];

  always #5 clk = ~clk;

  imem_fetch_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_instr(resp_instr[0]), .resp_err(resp_err[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(fetch_cnt[0]));

  imem_fetch_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_instr(resp_instr[1]), .resp_err(resp_err[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(fetch_cnt[1]));

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 3;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE) || (64'(a) >= 64'(BASE) + 64'(4 * DEPTH));
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    if (!addr_bad(a)) mdl_mem[word_idx(a)] = d;
    #1 ld_en = 1'b0;
  endtask

  // One complete fetch on channel s: request, latency, hold with resp_ready low, handshake.
  task automatic fetch(input int s, input logic [31:0] a, input int hold,
                       input bit same_ld, input logic [31:0] ld_d);
    logic [31:0] exp_i;
    logic        exp_e;
    int          k;
    @(negedge clk);
    nchecks++; if (req_ready[s] !== 1'b1) begin nerr++; $display("FAIL req_ready_idle s=%0d: got %b want 1", s, req_ready[s]); end
    exp_e = addr_bad(a);
    exp_i = exp_e ? ERR_INSTR : mdl_mem[word_idx(a)];
    req_valid[s] = 1'b1; req_addr[s] = a;
    if (same_ld) begin ld_en = 1'b1; ld_addr = a; ld_data = ld_d; end
    @(posedge clk);
    if (same_ld && !exp_e) mdl_mem[word_idx(a)] = ld_d;
    @(negedge clk);
    req_valid[s] = 1'b0; ld_en = 1'b0;
    k = 0;
    while (resp_valid[s] !== 1'b1 && k < 20) begin
      nchecks++; if (req_ready[s] !== 1'b0) begin nerr++; $display("FAIL req_ready_wait s=%0d: got %b want 0", s, req_ready[s]); end
      @(negedge clk);
      k++;
    end
    nchecks++; if (k != lat_of(s) - 1) begin nerr++; $display("FAIL latency s=%0d a=%h: got %0d want %0d", s, a, k, lat_of(s) - 1); end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      nchecks++; if (resp_valid[s] !== 1'b1) begin nerr++; $display("FAIL resp_valid_hold s=%0d: got %b want 1", s, resp_valid[s]); end
      nchecks++; if (resp_instr[s] !== exp_i) begin nerr++; $display("FAIL instr s=%0d a=%h: got %h want %h", s, a, resp_instr[s], exp_i); end
      nchecks++; if (resp_err[s] !== exp_e) begin nerr++; $display("FAIL err s=%0d a=%h: got %b want %b", s, a, resp_err[s], exp_e); end
      nchecks++; if (req_ready[s] !== 1'b0) begin nerr++; $display("FAIL req_ready_resp s=%0d: got %b want 0", s, req_ready[s]); end
      nchecks++; if (fetch_cnt[s] !== mdl_cnt[s]) begin nerr++; $display("FAIL cnt_hold s=%0d: got %h want %h", s, fetch_cnt[s], mdl_cnt[s]); end
    end
    resp_ready[s] = 1'b1;
    @(negedge clk);
    resp_ready[s] = 1'b0;
    mdl_cnt[s] = mdl_cnt[s] + 32'd1;
    nchecks++; if (fetch_cnt[s] !== mdl_cnt[s]) begin nerr++; $display("FAIL cnt s=%0d: got %h want %h", s, fetch_cnt[s], mdl_cnt[s]); end
    nchecks++; if (resp_valid[s] !== 1'b0) begin nerr++; $display("FAIL resp_valid_done s=%0d: got %b want 0", s, resp_valid[s]); end
    nchecks++; if (req_ready[s] !== 1'b1) begin nerr++; $display("FAIL req_ready_done s=%0d: got %b want 1", s, req_ready[s]); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      nchecks++; if (resp_valid[s] !== 1'b0) begin nerr++; $display("FAIL rst_valid s=%0d: got %b want 0", s, resp_valid[s]); end
      nchecks++; if (resp_instr[s] !== 32'h0) begin nerr++; $display("FAIL rst_instr s=%0d: got %h want 0", s, resp_instr[s]); end
      nchecks++; if (resp_err[s] !== 1'b0) begin nerr++; $display("FAIL rst_err s=%0d: got %b want 0", s, resp_err[s]); end
      nchecks++; if (fetch_cnt[s] !== 32'h0) begin nerr++; $display("FAIL rst_cnt s=%0d: got %h want 0", s, fetch_cnt[s]); end
      nchecks++; if (req_ready[s] !== 1'b0) begin nerr++; $display("FAIL rst_ready s=%0d: got %b want 0", s, req_ready[s]); end
      mdl_cnt[s] = 32'h0;
    end
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      nchecks++; if (req_ready[s] !== 1'b1) begin nerr++; $display("FAIL rst_release_ready s=%0d: got %b want 1", s, req_ready[s]); end
    end
  endtask

  task automatic test_basic;
    load_word(32'h80000000, 32'h00500093);
    fetch(0, 32'h80000000, 0, 1'b0, 32'h0);
    nchecks++; if (fetch_cnt[0] !== 32'd1) begin nerr++; $display("FAIL basic_cnt: got %h want 1", fetch_cnt[0]); end
  endtask

  task automatic test_latency;
    load_word(32'h80000004, 32'h12345678);
    fetch(1, 32'h80000004, 4, 1'b0, 32'h0);
  endtask

  task automatic test_preload;
    for (int i = 0; i < DEPTH; i++) load_word(BASE + 32'(4 * i), $urandom);
  endtask

  task automatic test_errors;
    fetch(0, 32'h80000002, 1, 1'b0, 32'h0);
    fetch(1, 32'h80001000, 0, 1'b0, 32'h0);
    fetch(0, 32'h7FFFFFFC, 0, 1'b0, 32'h0);
    fetch(1, 32'h80000FFC, 0, 1'b0, 32'h0);
    // Out-of-range and misaligned loads must be ignored.
    load_word(32'h80001000, 32'hDEADBEEF);
    load_word(32'h80000011, 32'hDEADBEEF);
    fetch(0, 32'h80000010, 0, 1'b0, 32'h0);
  endtask

  task automatic test_same_cycle_load;
    load_word(32'h80000008, 32'h55550000);
    fetch(0, 32'h80000008, 0, 1'b1, 32'hAAAA0000);
    fetch(1, 32'h80000008, 0, 1'b0, 32'h0);
  endtask

  task automatic test_ready_idle;
    @(negedge clk);
    resp_ready[0] = 1'b1; resp_ready[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        nchecks++; if (fetch_cnt[s] !== mdl_cnt[s]) begin nerr++; $display("FAIL idle_ready_cnt s=%0d: got %h want %h", s, fetch_cnt[s], mdl_cnt[s]); end
        nchecks++; if (resp_valid[s] !== 1'b0) begin nerr++; $display("FAIL idle_ready_valid s=%0d: got %b want 0", s, resp_valid[s]); end
      end
    end
    resp_ready[0] = 1'b0; resp_ready[1] = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        4:          a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        5:          a = 32'($urandom_range(0, 32'h7FFFFFFF));
        6:          a = ($urandom_range(0, 1) == 0) ? BASE + 32'(4 * DEPTH) : 32'hFFFFFFFC;
        default:    a = BASE + 32'(4 * (DEPTH - 1));
      endcase
      if ($urandom_range(0, 3) == 0) load_word(BASE + 32'(4 * $urandom_range(0, DEPTH)), $urandom);
      fetch(int'($urandom_range(0, 1)), a, int'($urandom_range(0, 3)),
            ($urandom_range(0, 4) == 0), $urandom);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = BASE;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) mdl_cnt[s] = 32'h0;
    nchecks++; if (resp_valid[1] !== 1'b0) begin nerr++; $display("FAIL midrst_valid: got %b want 0", resp_valid[1]); end
    nchecks++; if (fetch_cnt[1] !== 32'h0) begin nerr++; $display("FAIL midrst_cnt: got %h want 0", fetch_cnt[1]); end
    nchecks++; if (req_ready[1] !== 1'b0) begin nerr++; $display("FAIL midrst_ready_in_rst: got %b want 0", req_ready[1]); end
    rst = 1'b0;
    #1;
    nchecks++; if (req_ready[1] !== 1'b1) begin nerr++; $display("FAIL midrst_ready_after: got %b want 1", req_ready[1]); end
    repeat (4) begin
      @(negedge clk);
      nchecks++; if (resp_valid[1] !== 1'b0) begin nerr++; $display("FAIL midrst_dropped: got %b want 0", resp_valid[1]); end
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force u_lat1.fetch_cnt = 32'hFFFFFFFF;
    force u_lat3.fetch_cnt = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    release u_lat1.fetch_cnt;
    release u_lat3.fetch_cnt;
    for (int s = 0; s < 2; s++) mdl_cnt[s] = 32'hFFFFFFFF;
    #1;
    for (int s = 0; s < 2; s++) begin
      nchecks++; if (fetch_cnt[s] !== 32'hFFFFFFFF) begin nerr++; $display("FAIL wrap_preset s=%0d: got %h want ffffffff", s, fetch_cnt[s]); end
    end
    fetch(0, 32'h80000000, 0, 1'b0, 32'h0);
    fetch(1, 32'h80000003, 1, 1'b0, 32'h0);
    nchecks++; if (fetch_cnt[0] !== 32'h0) begin nerr++; $display("FAIL wrap_zero: got %h want 0", fetch_cnt[0]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_addr[s] = 32'h0; resp_ready[s] = 1'b0; mdl_cnt[s] = 32'h0;
    end
    test_reset();
    test_basic();
    test_latency();
    test_preload();
    test_errors();
    test_same_cycle_load();
    test_ready_idle();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
